// File: rtl/usb4_multigen_clk_rst_gen.sv
// Fractional-N clock-enable generator and reset sequencer for the USB4 logical layer.
// Each channel strobes when its phase accumulator carries; rst_out_n is released after RST_HOLD strobes of RST_CH.
module usb4_multigen_clk_rst_gen #(
  parameter int unsigned        NUM_CH   = 8,
  parameter int unsigned        ACC_W    = 32,
  parameter logic [ACC_W-1:0]   DEF_INC  = {ACC_W{1'b0}},
  parameter int unsigned        RST_CH   = 0,
  parameter int unsigned        RST_HOLD = 3,
  localparam int unsigned       CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              local_clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              sw_rst_req,
  output logic [NUM_CH-1:0] stb_o,
  output logic [NUM_CH-1:0] div_clk_o,
  output logic              rst_out_n,
  output logic              rst_done
);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_RUN   = 2'd2
  } seq_state_e;

  localparam logic [7:0] RST_HOLD_C = 8'(RST_HOLD);

  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [ACC_W-1:0]  inc_q [NUM_CH];
  logic [ACC_W-1:0]  inc_d [NUM_CH];
  logic [NUM_CH-1:0] stb_q;
  logic [NUM_CH-1:0] stb_d;
  logic [NUM_CH-1:0] div_q;
  logic [NUM_CH-1:0] div_d;
  seq_state_e        state_q;
  logic [7:0]        cnt_q;
  logic              rst_out_n_q;
  logic              rst_done_q;

  // Channel next state: a config write restarts the phase and beats the accumulate
  always_comb begin
    logic [ACC_W:0] sum;
    sum   = {(ACC_W+1){1'b0}};
    stb_d = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      acc_d[c] = acc_q[c];
      inc_d[c] = inc_q[c];
      sum      = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
      if (cfg_wr && (32'(cfg_ch) == 32'(c))) begin
        inc_d[c] = cfg_inc;
        acc_d[c] = {ACC_W{1'b0}};
      end else if (ch_en[c]) begin
        acc_d[c] = sum[ACC_W-1:0];
        stb_d[c] = sum[ACC_W];
      end else begin
        acc_d[c] = acc_q[c];
      end
    end
    div_d = div_q ^ stb_d;
  end

  // Channel registers
  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= {ACC_W{1'b0}};
        inc_q[c] <= DEF_INC;
      end
      stb_q <= {NUM_CH{1'b0}};
      div_q <= {NUM_CH{1'b0}};
    end else begin
      acc_q <= acc_d;
      inc_q <= inc_d;
      stb_q <= stb_d;
      div_q <= div_d;
    end
  end

  // Reset sequencer; a software request restarts from HOLD and wins over count completion
  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HOLD;
      cnt_q       <= 8'd0;
      rst_out_n_q <= 1'b0;
      rst_done_q  <= 1'b0;
    end else if (sw_rst_req) begin
      state_q     <= ST_HOLD;
      cnt_q       <= 8'd0;
      rst_out_n_q <= 1'b0;
      rst_done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          state_q     <= ST_COUNT;
          cnt_q       <= 8'd0;
          rst_out_n_q <= 1'b0;
          rst_done_q  <= 1'b0;
        end
        ST_COUNT: begin
          if (cnt_q == RST_HOLD_C) begin
            state_q     <= ST_RUN;
            rst_out_n_q <= 1'b1;
            rst_done_q  <= 1'b1;
          end else if (stb_q[RST_CH]) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q <= cnt_q;
          end
        end
        ST_RUN: begin
          rst_out_n_q <= 1'b1;
          rst_done_q  <= 1'b1;
        end
        default: begin
          state_q     <= ST_HOLD;
          cnt_q       <= 8'd0;
          rst_out_n_q <= 1'b0;
          rst_done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign stb_o     = stb_q;
  assign div_clk_o = div_q;
  assign rst_out_n = rst_out_n_q;
  assign rst_done  = rst_done_q;

endmodule

// File: tb/tb_usb4_multigen_clk_rst_gen.sv
// Directed bench for usb4_multigen_clk_rst_gen: strobe rates, divided clocks, reset sequencing.
// Six channels so that cfg_ch = 6 is an encodable but out-of-range index.
module tb_usb4_multigen_clk_rst_gen;

  logic        local_clk;
  logic        rst;
  logic [5:0]  ch_en;
  logic        cfg_wr;
  logic [2:0]  cfg_ch;
  logic [31:0] cfg_inc;
  logic        sw_rst_req;
  logic [5:0]  stb_o;
  logic [5:0]  div_clk_o;
  logic        rst_out_n;
  logic        rst_done;

  int   errors = 0;
  int   checks = 0;
  logic exp_div0;

  usb4_multigen_clk_rst_gen #(
    .NUM_CH(6), .ACC_W(32), .DEF_INC(32'd0), .RST_CH(0), .RST_HOLD(3)
  ) dut (
    .local_clk(local_clk), .rst(rst), .ch_en(ch_en), .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .sw_rst_req(sw_rst_req),
    .stb_o(stb_o), .div_clk_o(div_clk_o), .rst_out_n(rst_out_n), .rst_done(rst_done)
  );

  initial local_clk = 1'b0;
  always #5 local_clk = ~local_clk;

  task automatic tick();
    @(posedge local_clk);
    @(negedge local_clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; ch_en = 6'd0; cfg_wr = 1'b0; cfg_ch = 3'd0; cfg_inc = 32'd0; sw_rst_req = 1'b0;
    exp_div0 = 1'b0;
    repeat (3) @(negedge local_clk);
    checks++; if (stb_o !== 6'd0) begin errors++; $display("FAIL reset_stb got=%h exp=00", stb_o); end
    checks++; if (div_clk_o !== 6'd0) begin errors++; $display("FAIL reset_div got=%h exp=00", div_clk_o); end
    checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL reset_rst_out_n got=%b exp=0", rst_out_n); end
    checks++; if (rst_done !== 1'b0) begin errors++; $display("FAIL reset_rst_done got=%b exp=0", rst_done); end
    rst = 1'b1;
    repeat (4) tick();
    checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL idle_rst_out_n got=%b exp=0", rst_out_n); end
    checks++; if (stb_o !== 6'd0) begin errors++; $display("FAIL idle_stb got=%h exp=00", stb_o); end
  endtask

  // ch0 at inc=2^29 strobes every 8 cycles; third strobe releases rst_out_n at cycle 26
  task automatic test_ch0_release(input int n_cycles);
    logic exp_stb;
    logic exp_rel;
    cfg_wr = 1'b1; cfg_ch = 3'd0; cfg_inc = 32'h2000_0000;
    tick();
    cfg_wr = 1'b0; ch_en[0] = 1'b1;
    for (int k = 1; k <= n_cycles; k++) begin
      tick();
      exp_stb = (k % 8 == 0);
      if (exp_stb) exp_div0 = ~exp_div0;
      exp_rel = (k >= 26);
      checks++; if (stb_o[0] !== exp_stb) begin errors++; $display("FAIL rel_stb0 k=%0d got=%b exp=%b", k, stb_o[0], exp_stb); end
      checks++; if (div_clk_o[0] !== exp_div0) begin errors++; $display("FAIL rel_div0 k=%0d got=%b exp=%b", k, div_clk_o[0], exp_div0); end
      checks++; if (rst_out_n !== exp_rel) begin errors++; $display("FAIL rel_rst_out_n k=%0d got=%b exp=%b", k, rst_out_n, exp_rel); end
      checks++; if (rst_done !== exp_rel) begin errors++; $display("FAIL rel_rst_done k=%0d got=%b exp=%b", k, rst_done, exp_rel); end
    end
  endtask

  // Requests at 41 (in RUN), 71 (in RUN) and 84 (mid-count, restarting from 0)
  task automatic test_sw_rst();
    logic exp_stb;
    logic exp_rel;
    for (int k = 41; k <= 110; k++) begin
      sw_rst_req = (k == 41) || (k == 71) || (k == 84);
      tick();
      sw_rst_req = 1'b0;
      exp_stb = (k % 8 == 0);
      if (exp_stb) exp_div0 = ~exp_div0;
      exp_rel = ((k >= 66) && (k <= 70)) || (k >= 106);
      checks++; if (stb_o[0] !== exp_stb) begin errors++; $display("FAIL sw_stb0 k=%0d got=%b exp=%b", k, stb_o[0], exp_stb); end
      checks++; if (rst_out_n !== exp_rel) begin errors++; $display("FAIL sw_rst_out_n k=%0d got=%b exp=%b", k, rst_out_n, exp_rel); end
      checks++; if (rst_done !== exp_rel) begin errors++; $display("FAIL sw_rst_done k=%0d got=%b exp=%b", k, rst_done, exp_rel); end
    end
  endtask

  // Rate change to 2^30 mid-count at 120, out-of-range write at 135
  task automatic test_cfg_rewrite();
    logic exp_stb;
    logic exp_rel;
    for (int k = 111; k <= 150; k++) begin
      sw_rst_req = (k == 111);
      cfg_wr     = (k == 120) || (k == 135);
      cfg_ch     = (k == 135) ? 3'd6 : 3'd0;
      cfg_inc    = (k == 135) ? 32'h8000_0000 : 32'h4000_0000;
      tick();
      sw_rst_req = 1'b0; cfg_wr = 1'b0;
      if (k < 120)       exp_stb = (k % 8 == 0);
      else if (k == 120) exp_stb = 1'b0;
      else               exp_stb = ((k - 120) % 4 == 0);
      if (exp_stb) exp_div0 = ~exp_div0;
      exp_rel = (k >= 130);
      checks++; if (stb_o !== {5'd0, exp_stb}) begin errors++; $display("FAIL cfg_stb k=%0d got=%h exp=%h", k, stb_o, {5'd0, exp_stb}); end
      checks++; if (div_clk_o[0] !== exp_div0) begin errors++; $display("FAIL cfg_div0 k=%0d got=%b exp=%b", k, div_clk_o[0], exp_div0); end
      checks++; if (rst_out_n !== exp_rel) begin errors++; $display("FAIL cfg_rst_out_n k=%0d got=%b exp=%b", k, rst_out_n, exp_rel); end
    end
  endtask

  // 80000 cycles: ch1 (2^31) -> 40000, ch2 (520603723) -> floor(80000*inc/2^32) = 9696, ch0 (2^30) -> 20000
  task automatic test_multi_rate();
    int c0, c1, c2;
    c0 = 0; c1 = 0; c2 = 0;
    cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_inc = 32'h8000_0000;
    tick();
    cfg_ch = 3'd2; cfg_inc = 32'd520603723;
    tick();
    cfg_wr = 1'b0; ch_en[2:1] = 2'b11;
    for (int k = 0; k < 80000; k++) begin
      tick();
      if (stb_o[0]) c0++;
      if (stb_o[1]) c1++;
      if (stb_o[2]) c2++;
    end
    checks++; if (c1 !== 40000) begin errors++; $display("FAIL multi_ch1 got=%0d exp=40000", c1); end
    checks++; if (c2 !== 9696) begin errors++; $display("FAIL multi_ch2 got=%0d exp=9696", c2); end
    checks++; if (c0 !== 20000) begin errors++; $display("FAIL multi_ch0 got=%0d exp=20000", c0); end
    checks++; if (div_clk_o[1] !== 1'b0) begin errors++; $display("FAIL multi_div1 got=%b exp=0", div_clk_o[1]); end
    checks++; if (rst_done !== 1'b1) begin errors++; $display("FAIL multi_rst_done got=%b exp=1", rst_done); end
  endtask

  task automatic test_disable_async_reset();
    ch_en[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (stb_o[1] !== 1'b0) begin errors++; $display("FAIL dis_stb1 i=%0d got=%b exp=0", i, stb_o[1]); end
      checks++; if (div_clk_o[1] !== 1'b0) begin errors++; $display("FAIL dis_div1 i=%0d got=%b exp=0", i, div_clk_o[1]); end
    end
    // Accumulator held at 0, so the carry comes on the second enabled cycle
    ch_en[1] = 1'b1;
    tick();
    checks++; if (stb_o[1] !== 1'b0) begin errors++; $display("FAIL reen_stb1_a got=%b exp=0", stb_o[1]); end
    tick();
    checks++; if (stb_o[1] !== 1'b1) begin errors++; $display("FAIL reen_stb1_b got=%b exp=1", stb_o[1]); end
    checks++; if (div_clk_o[1] !== 1'b1) begin errors++; $display("FAIL reen_div1 got=%b exp=1", div_clk_o[1]); end
    @(posedge local_clk);
    #3 rst = 1'b0;
    #1;
    checks++; if (stb_o !== 6'd0) begin errors++; $display("FAIL async_stb got=%h exp=00", stb_o); end
    checks++; if (div_clk_o !== 6'd0) begin errors++; $display("FAIL async_div got=%h exp=00", div_clk_o); end
    checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL async_rst_out_n got=%b exp=0", rst_out_n); end
    checks++; if (rst_done !== 1'b0) begin errors++; $display("FAIL async_rst_done got=%b exp=0", rst_done); end
    @(negedge local_clk);
    rst = 1'b1; ch_en = 6'h3f;
    repeat (4) tick();
    checks++; if (stb_o !== 6'd0) begin errors++; $display("FAIL post_rst_stb got=%h exp=00", stb_o); end
    checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL post_rst_out_n got=%b exp=0", rst_out_n); end
    ch_en = 6'd0; exp_div0 = 1'b0;
    test_ch0_release(30);
  endtask

  initial begin
    test_reset();
    test_ch0_release(40);
    test_sw_rst();
    test_cfg_rewrite();
    test_multi_rate();
    test_disable_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
